// File: rtl/tnoc_flit_if_distributor.sv
// rtl/tnoc_flit_if_distributor.sv - per-VC packet distributor from one flit stream to ENTRIES outputs
// Flit layout: {head, tail, data[DATA_WIDTH-1:0]}; route selector sits at data[ROUTE_LSB +: SEL_WIDTH].
module tnoc_flit_if_distributor #(
    parameter int ENTRIES    = 2,
    parameter int CHANNELS   = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ROUTE_LSB  = 0,
    localparam int SEL_WIDTH  = $clog2(ENTRIES),
    localparam int FLIT_WIDTH = DATA_WIDTH + 2
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [CHANNELS-1:0]                              i_flit_in_valid,
    output logic [CHANNELS-1:0]                              o_flit_in_ready,
    input  logic [CHANNELS-1:0][FLIT_WIDTH-1:0]              i_flit_in_flit,
    output logic [CHANNELS-1:0]                              o_flit_in_vc_available,
    output logic [ENTRIES-1:0][CHANNELS-1:0]                 o_flit_out_valid,
    input  logic [ENTRIES-1:0][CHANNELS-1:0]                 i_flit_out_ready,
    output logic [ENTRIES-1:0][CHANNELS-1:0][FLIT_WIDTH-1:0] o_flit_out_flit,
    input  logic [ENTRIES-1:0][CHANNELS-1:0]                 i_flit_out_vc_available,
    output logic [CHANNELS-1:0]                              o_drop
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        DROP  = 2'd2
    } state_t;

    localparam logic [SEL_WIDTH:0] ENTRIES_W = (SEL_WIDTH + 1)'(ENTRIES);

    for (genvar v = 0; v < CHANNELS; v++) begin : g_vc
        state_t                  r_state;
        state_t                  w_state_next;
        logic                    r_valid;
        logic [FLIT_WIDTH-1:0]   r_flit;
        logic [SEL_WIDTH-1:0]    r_port;
        logic [SEL_WIDTH-1:0]    r_lock;
        logic                    r_drop;

        logic                    w_head;
        logic                    w_tail;
        logic [SEL_WIDTH-1:0]    w_sel;
        logic                    w_sel_ok;
        logic                    w_drain;
        logic                    w_space;
        logic                    w_ready;
        logic                    w_load;
        logic [SEL_WIDTH-1:0]    w_load_port;
        logic [SEL_WIDTH-1:0]    w_lock_next;
        logic                    w_drop_next;
        logic                    w_vc_available;

        assign w_head   = i_flit_in_flit[v][FLIT_WIDTH-1];
        assign w_tail   = i_flit_in_flit[v][FLIT_WIDTH-2];
        assign w_sel    = i_flit_in_flit[v][ROUTE_LSB +: SEL_WIDTH];
        assign w_sel_ok = {1'b0, w_sel} < ENTRIES_W;
        assign w_drain  = r_valid && i_flit_out_ready[r_port][v];
        assign w_space  = !r_valid || i_flit_out_ready[r_port][v];

        always_comb begin
            w_state_next   = r_state;
            w_ready        = w_space;
            w_load         = 1'b0;
            w_load_port    = r_lock;
            w_lock_next    = r_lock;
            w_drop_next    = 1'b0;
            w_vc_available = 1'b1;
            case (r_state)
                IDLE: begin
                    if (i_flit_in_valid[v]) begin
                        if (w_head && w_sel_ok) begin
                            w_load      = w_space;
                            w_load_port = w_sel;
                            if (w_space && !w_tail) begin
                                w_state_next = ROUTE;
                                w_lock_next  = w_sel;
                            end
                        end else begin
                            // bad selector or orphan body/tail: swallow it and flag once
                            w_ready     = 1'b1;
                            w_drop_next = 1'b1;
                            if (w_head && !w_tail) begin
                                w_state_next = DROP;
                            end
                        end
                    end
                end
                ROUTE: begin
                    w_vc_available = i_flit_out_vc_available[r_lock][v];
                    w_load         = i_flit_in_valid[v] && w_space;
                    if (w_load && w_tail) begin
                        w_state_next = IDLE;
                    end
                end
                DROP: begin
                    w_ready = 1'b1;
                    if (i_flit_in_valid[v] && w_tail) begin
                        w_state_next = IDLE;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state <= IDLE;
                r_valid <= 1'b0;
                r_flit  <= '0;
                r_port  <= '0;
                r_lock  <= '0;
                r_drop  <= 1'b0;
            end else begin
                r_state <= w_state_next;
                r_lock  <= w_lock_next;
                r_drop  <= w_drop_next;
                // a load wins over a drain, so back-to-back flits never leave a bubble
                if (w_load) begin
                    r_valid <= 1'b1;
                    r_flit  <= i_flit_in_flit[v];
                    r_port  <= w_load_port;
                end else if (w_drain) begin
                    r_valid <= 1'b0;
                end
            end
        end

        assign o_flit_in_ready[v]        = w_ready;
        assign o_flit_in_vc_available[v] = w_vc_available;
        assign o_drop[v]                 = r_drop;

        for (genvar p = 0; p < ENTRIES; p++) begin : g_port
            assign o_flit_out_valid[p][v] = r_valid && (r_port == SEL_WIDTH'(p));
            assign o_flit_out_flit[p][v]  = r_flit;
        end
    end

endmodule

// File: tb/tb_tnoc_flit_if_distributor.sv
// tb/tb_tnoc_flit_if_distributor.sv - scoreboard bench for tnoc_flit_if_distributor
module tb_tnoc_flit_if_distributor;

    localparam int ENTRIES    = 3;
    localparam int CHANNELS   = 2;
    localparam int DATA_WIDTH = 16;
    localparam int SEL_WIDTH  = 2;
    localparam int FW         = DATA_WIDTH + 2;
    localparam int BOUND      = 500;

    typedef logic [FW-1:0] flit_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                                     vld0, vld1;
    flit_t                                    fl0, fl1;
    logic [CHANNELS-1:0]                      in_valid;
    logic [CHANNELS-1:0]                      in_ready;
    logic [CHANNELS-1:0][FW-1:0]              in_flit;
    logic [CHANNELS-1:0]                      in_vca;
    logic [ENTRIES-1:0][CHANNELS-1:0]         out_valid;
    logic [ENTRIES-1:0][CHANNELS-1:0]         out_ready;
    logic [ENTRIES-1:0][CHANNELS-1:0][FW-1:0] out_flit;
    logic [ENTRIES-1:0][CHANNELS-1:0]         out_vca;
    logic [CHANNELS-1:0]                      drop;

    assign in_valid = {vld1, vld0};
    assign in_flit  = {fl1, fl0};

    tnoc_flit_if_distributor #(
        .ENTRIES    (ENTRIES),
        .CHANNELS   (CHANNELS),
        .DATA_WIDTH (DATA_WIDTH),
        .ROUTE_LSB  (0)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .i_flit_in_valid         (in_valid),
        .o_flit_in_ready         (in_ready),
        .i_flit_in_flit          (in_flit),
        .o_flit_in_vc_available  (in_vca),
        .o_flit_out_valid        (out_valid),
        .i_flit_out_ready        (out_ready),
        .o_flit_out_flit         (out_flit),
        .i_flit_out_vc_available (out_vca),
        .o_drop                  (drop)
    );

    int    errors = 0;
    int    checks = 0;
    flit_t exp_q [ENTRIES][CHANNELS][$];
    int    exp_drop [CHANNELS];
    int    got_drop [CHANNELS];
    bit    route_on [CHANNELS];
    int    route_port [CHANNELS];
    bit    rdy_random = 1'b0;
    logic [ENTRIES-1:0][CHANNELS-1:0] rdy_hold_low = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic flit_t make_head(input logic [DATA_WIDTH-1:0] hdata, input int sel, input bit tail);
        return {1'b1, tail, hdata[DATA_WIDTH-1:SEL_WIDTH], SEL_WIDTH'(sel)};
    endfunction

    // destination ready / vc_available driven just after each rising edge
    initial begin
        out_ready = '1;
        out_vca   = '1;
        forever begin
            @(posedge clk);
            #1;
            for (int p = 0; p < ENTRIES; p++) begin
                for (int v = 0; v < CHANNELS; v++) begin
                    out_ready[p][v] = rdy_random ? ($urandom_range(0, 3) != 0) : 1'b1;
                    out_vca[p][v]   = 1'($urandom_range(0, 1));
                end
            end
            out_ready = out_ready & ~rdy_hold_low;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int p = 0; p < ENTRIES; p++) begin
                for (int v = 0; v < CHANNELS; v++) begin
                    if (out_valid[p][v] && out_ready[p][v]) begin
                        if (exp_q[p][v].size() == 0) begin
                            check($sformatf("unexpected_out p%0d v%0d", p, v), 64'(out_flit[p][v]), 64'hDEAD);
                        end else begin
                            check($sformatf("out_flit p%0d v%0d", p, v), 64'(out_flit[p][v]), 64'(exp_q[p][v].pop_front()));
                        end
                    end
                end
            end
            for (int v = 0; v < CHANNELS; v++) begin
                if (drop[v]) got_drop[v]++;
                check($sformatf("vc_available v%0d", v), 64'(in_vca[v]),
                      route_on[v] ? 64'(out_vca[route_port[v]][v]) : 64'd1);
            end
        end
    end

    task automatic set_in(input int v, input logic valid, input flit_t f);
        if (v == 0) begin vld0 = valid; fl0 = f; end
        else        begin vld1 = valid; fl1 = f; end
    endtask

    task automatic send_flit(input int v, input flit_t f, output int stalls);
        bit acc = 1'b0;
        stalls = 0;
        set_in(v, 1'b1, f);
        while (!acc) begin
            @(negedge clk);
            acc = in_ready[v];
            @(posedge clk);
            #2;
            if (!acc) begin
                stalls++;
                if (stalls >= BOUND) begin
                    check($sformatf("accept_timeout v%0d", v), 64'd0, 64'd1);
                    break;
                end
            end
        end
        set_in(v, 1'b0, '0);
    endtask

    task automatic send_packet(input int v, input int sel, input int len,
                               input logic [DATA_WIDTH-1:0] hdata, output int stalls);
        flit_t fl [$];
        bit    legal = (sel < ENTRIES);
        int    s;
        stalls = 0;
        for (int i = 0; i < len; i++) begin
            if (i == 0) fl.push_back(make_head(hdata, sel, len == 1));
            else        fl.push_back({1'b0, (i == len - 1), DATA_WIDTH'($urandom)});
        end
        if (legal) begin
            foreach (fl[i]) exp_q[sel][v].push_back(fl[i]);
        end else begin
            exp_drop[v]++;
        end
        for (int i = 0; i < len; i++) begin
            send_flit(v, fl[i], s);
            stalls += s;
            if (i == 0 && legal && len > 1) begin
                route_port[v] = sel;
                route_on[v]   = 1'b1;
            end
        end
        route_on[v] = 1'b0;
    endtask

    task automatic send_orphan(input int v);
        int s;
        exp_drop[v]++;
        send_flit(v, {1'b0, 1'($urandom_range(0, 1)), DATA_WIDTH'($urandom)}, s);
    endtask

    task automatic wait_idle();
        int n = 0;
        bit busy = 1'b1;
        while (busy && n < 100) begin
            busy = 1'b0;
            for (int p = 0; p < ENTRIES; p++)
                for (int v = 0; v < CHANNELS; v++)
                    if (exp_q[p][v].size() != 0) busy = 1'b1;
            @(posedge clk);
            #2;
            n++;
        end
        repeat (2) @(posedge clk);
        #2;
        for (int p = 0; p < ENTRIES; p++)
            for (int v = 0; v < CHANNELS; v++)
                check($sformatf("drained p%0d v%0d", p, v), 64'(exp_q[p][v].size()), 64'd0);
    endtask

    task automatic rand_traffic(input int v);
        int s;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) send_orphan(v);
            else send_packet(v, $urandom_range(0, 3), $urandom_range(1, 4), DATA_WIDTH'($urandom), s);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #2;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            s, d0;
        flit_t         hf;
        logic [DATA_WIDTH-1:0] hd;
        for (int v = 0; v < CHANNELS; v++) begin
            exp_drop[v] = 0; got_drop[v] = 0; route_on[v] = 0; route_port[v] = 0;
        end
        vld0 = 0; vld1 = 0; fl0 = '0; fl1 = '0;
        rst = 1'b1;
        #12;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset drop", 64'(drop), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'h3);
        check("reset vc_available", 64'(in_vca), 64'h3);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #2;

        // single-flit packet, sel=1, one-cycle latency
        hd = DATA_WIDTH'($urandom);
        send_packet(0, 1, 1, hd, s);
        @(negedge clk);
        check("latency valid p1", 64'(out_valid[1][0]), 64'd1);
        check("latency idle p0", 64'(out_valid[0][0]), 64'd0);
        check("latency flit", 64'(out_flit[1][0]), 64'(make_head(hd, 1, 1'b1)));
        @(posedge clk);
        #2;
        wait_idle();

        // back-to-back 4-flit to port 0 and 3-flit to port 1
        begin
            int s1, s2;
            send_packet(0, 0, 4, DATA_WIDTH'($urandom), s1);
            send_packet(0, 1, 3, DATA_WIDTH'($urandom), s2);
            check("no_bubble stalls", 64'(s1 + s2), 64'd0);
        end
        wait_idle();

        // backpressure on port 0 VC0 for 5 cycles with the head held
        rdy_hold_low[0][0] = 1'b1;
        @(posedge clk);
        #2;
        hd = DATA_WIDTH'($urandom);
        hf = make_head(hd, 0, 1'b0);
        fork
            send_packet(0, 0, 4, hd, s);
            begin
                @(negedge clk);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("hold in_ready", 64'(in_ready[0]), 64'd0);
                    check("hold valid", 64'(out_valid[0][0]), 64'd1);
                    check("hold flit", 64'(out_flit[0][0]), 64'(hf));
                end
                rdy_hold_low[0][0] = 1'b0;
            end
        join
        wait_idle();

        // illegal selector packet, then a legal one
        d0 = got_drop[0];
        send_packet(0, 3, 3, DATA_WIDTH'($urandom), s);
        check("drop stalls", 64'(s), 64'd0);
        send_packet(0, 2, 2, DATA_WIDTH'($urandom), s);
        wait_idle();
        check("drop pulse once", 64'(got_drop[0] - d0), 64'd1);

        // orphan, then concurrent VC traffic to different ports
        d0 = got_drop[0];
        send_orphan(0);
        repeat (2) @(posedge clk);
        #2;
        check("orphan drop", 64'(got_drop[0] - d0), 64'd1);
        fork
            begin int sa; send_packet(0, 2, 4, DATA_WIDTH'($urandom), sa); end
            begin int sb; send_packet(1, 0, 4, DATA_WIDTH'($urandom), sb); end
        join
        wait_idle();

        // randomized traffic with random backpressure
        rdy_random = 1'b1;
        fork
            rand_traffic(0);
            rand_traffic(1);
        join
        rdy_random = 1'b0;
        wait_idle();
        for (int v = 0; v < CHANNELS; v++)
            check($sformatf("drop count v%0d", v), 64'(got_drop[v]), 64'(exp_drop[v]));

        // reset in the middle of a routed packet
        hd = DATA_WIDTH'($urandom);
        hf = make_head(hd, 2, 1'b0);
        exp_q[2][0].push_back(hf);
        send_flit(0, hf, s);
        route_port[0] = 2;
        route_on[0]   = 1'b1;
        send_flit(0, {1'b0, 1'b0, DATA_WIDTH'($urandom)}, s);
        #1;
        rst = 1'b1;
        #1;
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst drop", 64'(drop), 64'd0);
        check("rst in_ready", 64'(in_ready), 64'h3);
        check("rst vc_available", 64'(in_vca), 64'h3);
        route_on[0] = 1'b0;
        for (int p = 0; p < ENTRIES; p++)
            for (int v = 0; v < CHANNELS; v++)
                exp_q[p][v].delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #2;
        hd = DATA_WIDTH'($urandom);
        send_packet(0, 1, 1, hd, s);
        @(negedge clk);
        check("post-reset valid", 64'(out_valid[1][0]), 64'd1);
        check("post-reset flit", 64'(out_flit[1][0]), 64'(make_head(hd, 1, 1'b1)));
        @(posedge clk);
        #2;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
